fod_phe_sampler_dec: RTL and testbench
======================================

Name: fod_phe_sampler_dec

Overview:
- Sits between the phase-detect sampler flops and the FOD controller's PHE_X4 input.
- Each FDTC edge captures the 8-phase FMP_RND snapshot. This block decodes each snapshot into a 3-bit phase index, rejects bubbled or invalid patterns, and packs four consecutive codes into one PHE_X4 word with a valid strobe.
- It also keeps a saturating error count for calibration-health monitoring.

Parameters:
- MP_SEG_BIN, 3, bits per phase code; MP_SEG = 2**MP_SEG_BIN phases.
- LANES, 4, codes packed per PHE_X4 word.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  FDTC-rate clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  sample-enable; PSAMP is captured only when high.
- PSAMP  in  MP_SEG  raw phase snapshot, bit i = phase i.
- SYNC  in  1  lane-alignment pulse; restarts packing at lane 0.
- ERR_CLR  in  1  clears ERR_CNT.
- PHE_X4  out  LANES*MP_SEG_BIN  packed codes; lane j at bits [j*MP_SEG_BIN +: MP_SEG_BIN].
- PHE_VLD  out  1  one-cycle pulse when PHE_X4 updates.
- ERR  out  1  one-cycle pulse per invalid decoded sample.
- ERR_CNT  out  ERR_W  saturating invalid-sample count.

Behaviour:
- Reset (RST=1 at an edge; RST wins over everything):
  - samp_r=0, samp_vld=0, lane=0, shadow lanes=0, last_code=0.
  - PHE_X4=0, PHE_VLD=0, ERR=0, ERR_CNT=0.
- Stage 1, at edge t:
  - samp_r <= PSAMP.
  - samp_vld <= EN.
- Decode (combinational on samp_r):
  - A rising boundary exists at k when samp_r[k]=1 and samp_r[(k-1) mod MP_SEG]=0, with circular indexing.
  - Valid iff exactly one rising boundary exists; code = k.
  - All-zeros, all-ones and multi-boundary (bubble) patterns are invalid.
  - Invalid → code = last_code (hold previous valid code).
- Stage 2, at edge t+1, when samp_vld=1 and SYNC=0:
  - shadow[lane] <= code.
  - Valid sample: last_code <= code. Invalid sample: ERR <= 1.
  - lane < LANES-1: lane <= lane+1.
  - lane = LANES-1: PHE_X4 <= {code, shadow[LANES-2..0]}, PHE_VLD <= 1, lane <= 0.
- Latency: the lane-3 snapshot at PSAMP edge t appears on PHE_X4 with PHE_VLD=1 after edge t+1.
- samp_vld=0: no lane write, lane holds, PHE_VLD=0, ERR=0.
- PHE_VLD and ERR default to 0 on every other edge. PHE_X4 holds between updates.
- SYNC=1 at an edge:
  - lane <= 0 and shadow cleared.
  - Any sample in stage 2 that edge is discarded: no PHE_VLD, no ERR, no count.
  - The partially packed word is dropped.
  - samp_r still loads normally.
- ERR_CNT:
  - Increments on each ERR pulse and saturates at 2**ERR_W-1 (no wrap).
  - ERR_CLR=1 sets it to 0. If an error occurs on the same edge, ERR_CLR wins and the result is 0.
  - The ERR pulse itself is still emitted.
- EN deasserted mid-word: packing pauses and resumes at the same lane when EN returns. No timeout.
- Reset mid-word: the partial word is lost and PHE_X4 returns to 0.

Test Plan:
- Reset then EN=1 with PSAMP = 8'h0F, 8'h1E, 8'h3C, 8'h78 (codes 0,1,2,3) → single PHE_VLD one edge after the 4th sample is registered, PHE_X4 = 12'h688, ERR_CNT = 0.
- Wrap pattern PSAMP = 8'hE1 in all four lanes → code 5 in every lane, PHE_X4 = 12'hB6D.
- Bubble: lanes 2,3,4,5 then PSAMP = 8'h2D in lane 3 → lane 3 code = 4 (held), ERR pulses once, ERR_CNT = 1. Also 8'h00 and 8'hFF each increment ERR_CNT.
- SYNC asserted after two samples packed → no PHE_VLD for the partial word; next four samples form a word starting at lane 0. SYNC coinciding with an invalid sample → no ERR, no count.
- EN toggled 1,0,0,1 across a word → PHE_VLD fires only after the 4th enabled sample; lane order preserved.
- Drive 300 invalid samples → ERR_CNT = 255 and holds. ERR_CLR on the same edge as an ERR → ERR_CNT = 0.

Source files
------------

// File: rtl/fod_phe_sampler_dec.sv
// Decodes 8-phase FMP_RND sampler snapshots into 3-bit phase codes and packs
// four consecutive codes into one PHE_X4 word, with an invalid-sample monitor.
module fod_phe_sampler_dec #(
    parameter int MP_SEG_BIN = 3,
    parameter int LANES      = 4,
    parameter int ERR_W      = 8,
    localparam int MP_SEG    = 2**MP_SEG_BIN,
    localparam int PHE_W     = LANES * MP_SEG_BIN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [MP_SEG-1:0] PSAMP,
    input  logic              SYNC,
    input  logic              ERR_CLR,
    output logic [PHE_W-1:0]  PHE_X4,
    output logic              PHE_VLD,
    output logic              ERR,
    output logic [ERR_W-1:0]  ERR_CNT
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    logic [MP_SEG-1:0]     samp_r;
    logic                  samp_vld;
    logic [LANE_W-1:0]     lane;
    logic [MP_SEG_BIN-1:0] shadow [LANES];
    logic [MP_SEG_BIN-1:0] last_code;

    logic [MP_SEG-1:0]     rise;
    logic                  dec_valid;
    logic [MP_SEG_BIN-1:0] dec_idx;
    logic [MP_SEG_BIN-1:0] code;
    logic [PHE_W-1:0]      packed_word;
    logic                  take;
    logic                  err_now;

    // A rising boundary at k marks the first late phase after an early one,
    // scanning circularly; a clean snapshot has exactly one.
    always_comb begin
        rise = '0;
        for (int k = 0; k < MP_SEG; k++) begin
            rise[k] = samp_r[k] & ~samp_r[(k + MP_SEG - 1) % MP_SEG];
        end
    end

    always_comb begin
        dec_valid = (rise != '0) && ((rise & (rise - MP_SEG'(1))) == '0);
        dec_idx   = '0;
        for (int k = 0; k < MP_SEG; k++) begin
            if (rise[k]) begin
                dec_idx = MP_SEG_BIN'(k);
            end
        end
        code = dec_valid ? dec_idx : last_code;
    end

    // SYNC at the stage-2 edge discards whatever sample is sitting there.
    assign take    = samp_vld & ~SYNC;
    assign err_now = take & ~dec_valid;

    always_comb begin
        packed_word = '0;
        for (int j = 0; j < LANES - 1; j++) begin
            packed_word[j*MP_SEG_BIN +: MP_SEG_BIN] = shadow[j];
        end
        packed_word[(LANES-1)*MP_SEG_BIN +: MP_SEG_BIN] = code;
    end

    // PHE_VLD is a one-cycle strobe with no back-pressure: the consumer must
    // take PHE_X4 on the cycle PHE_VLD is high; PHE_X4 holds until the next word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            samp_r    <= '0;
            samp_vld  <= 1'b0;
            lane      <= '0;
            for (int j = 0; j < LANES; j++) begin
                shadow[j] <= '0;
            end
            last_code <= '0;
            PHE_X4    <= '0;
            PHE_VLD   <= 1'b0;
            ERR       <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            samp_r   <= PSAMP;
            samp_vld <= EN;
            PHE_VLD  <= 1'b0;
            ERR      <= err_now;

            if (SYNC) begin
                lane <= '0;
                for (int j = 0; j < LANES; j++) begin
                    shadow[j] <= '0;
                end
            end else if (samp_vld) begin
                shadow[lane] <= code;
                if (dec_valid) begin
                    last_code <= code;
                end
                if (lane == LANE_LAST) begin
                    PHE_X4  <= packed_word;
                    PHE_VLD <= 1'b1;
                    lane    <= '0;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end

            // Clear beats a same-edge error; the ERR pulse itself still fires.
            if (ERR_CLR) begin
                ERR_CNT <= '0;
            end else if (err_now && (ERR_CNT != ERR_MAX)) begin
                ERR_CNT <= ERR_CNT + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fod_phe_sampler_dec.sv
// Self-checking bench for fod_phe_sampler_dec: scenario tasks plus a word
// scoreboard popped whenever PHE_VLD strobes.
module tb_fod_phe_sampler_dec;

    localparam int MP_SEG_BIN = 3;
    localparam int LANES      = 4;
    localparam int ERR_W      = 8;
    localparam int MP_SEG     = 8;
    localparam int PHE_W      = 12;

    logic              CLK;
    logic              RST;
    logic              EN;
    logic [MP_SEG-1:0] PSAMP;
    logic              SYNC;
    logic              ERR_CLR;
    logic [PHE_W-1:0]  PHE_X4;
    logic              PHE_VLD;
    logic              ERR;
    logic [ERR_W-1:0]  ERR_CNT;

    fod_phe_sampler_dec #(
        .MP_SEG_BIN(MP_SEG_BIN),
        .LANES     (LANES),
        .ERR_W     (ERR_W)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .PSAMP  (PSAMP),
        .SYNC   (SYNC),
        .ERR_CLR(ERR_CLR),
        .PHE_X4 (PHE_X4),
        .PHE_VLD(PHE_VLD),
        .ERR    (ERR),
        .ERR_CNT(ERR_CNT)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [PHE_W-1:0] exp_q[$];
    int n_cmp   = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int vld_cyc = -1;

    always @(negedge CLK) begin
        logic [PHE_W-1:0] exp_w;
        if (PHE_VLD === 1'b1) begin
            vld_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL phe_word_unexpected: got %h, required no word", PHE_X4);
            end else begin
                exp_w = exp_q.pop_front();
                if (PHE_X4 !== exp_w) begin
                    n_fail++;
                    $display("FAIL phe_word: got %h, required %h", PHE_X4, exp_w);
                end
            end
        end
        if (ERR === 1'b1) err_seen++;
    end

    function automatic logic [PHE_W-1:0] word4(input int c3, input int c2,
                                               input int c1, input int c0);
        logic [PHE_W-1:0] w;
        w = {c3[2:0], c2[2:0], c1[2:0], c0[2:0]};
        return w;
    endfunction

    // driver tasks: inputs change on the falling edge
    task automatic step(input logic en, input logic [7:0] ps, input logic sync,
                        input logic clr);
        @(negedge CLK);
        RST = 1'b0; EN = en; PSAMP = ps; SYNC = sync; ERR_CLR = clr;
    endtask

    task automatic send(input logic [7:0] ps);
        step(1'b1, ps, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic flush();
        idle();
        idle();
        #1;
    endtask

    task automatic align();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; PSAMP = 8'h2D; SYNC = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        n_cmp++;
        if (PHE_X4 !== '0) begin n_fail++; $display("FAIL reset_phe_x4: got %h, required 000", PHE_X4); end
        n_cmp++;
        if (PHE_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_phe_vld: got %b, required 0", PHE_VLD); end
        n_cmp++;
        if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", ERR); end
        n_cmp++;
        if (ERR_CNT !== '0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d, required 0", ERR_CNT); end
        idle();
    endtask

    task automatic test_basic();
        int c;
        int e0;
        e0 = err_seen;
        exp_q.push_back(12'h688);
        send(8'h0F); send(8'h1E); send(8'h3C); send(8'h78);
        c = cyc;
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_word_missing: pending %0d, required 0", exp_q.size()); end
        n_cmp++;
        if (vld_cyc != c + 2) begin n_fail++; $display("FAIL basic_latency: vld at cycle %0d, required %0d", vld_cyc, c + 2); end
        n_cmp++;
        if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL basic_err_cnt: got %0d, required 0", ERR_CNT); end
        n_cmp++;
        if (err_seen != e0) begin n_fail++; $display("FAIL basic_err_pulses: got %0d, required 0", err_seen - e0); end
    endtask

    task automatic test_wrap();
        align();
        exp_q.push_back(12'hB6D);
        repeat (4) send(8'hE1);
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_word_missing: pending %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_bubble();
        int e0;
        align();
        e0 = err_seen;
        exp_q.push_back(12'h91A);
        send(8'h3C); send(8'h78); send(8'hF0); send(8'h2D);
        flush();
        n_cmp++;
        if (err_seen - e0 != 1) begin n_fail++; $display("FAIL bubble_err_pulses: got %0d, required 1", err_seen - e0); end
        n_cmp++;
        if (ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL bubble_err_cnt: got %0d, required 1", ERR_CNT); end
        exp_q.push_back(12'h224);
        send(8'h00); send(8'hFF); send(8'h0F); send(8'h1E);
        flush();
        n_cmp++;
        if (ERR_CNT !== 8'd3) begin n_fail++; $display("FAIL allzero_allone_err_cnt: got %0d, required 3", ERR_CNT); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bubble_word_missing: pending %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_sync();
        int e0;
        logic [ERR_W-1:0] cnt0;
        align();
        send(8'h0F); send(8'h1E);
        idle();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        exp_q.push_back(12'hB1A);
        send(8'h3C); send(8'h78); send(8'hF0); send(8'hE1);
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sync_word_missing: pending %0d, required 0", exp_q.size()); end
        e0 = err_seen;
        cnt0 = ERR_CNT;
        send(8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        flush();
        n_cmp++;
        if (err_seen != e0) begin n_fail++; $display("FAIL sync_err_discard: got %0d pulses, required 0", err_seen - e0); end
        n_cmp++;
        if (ERR_CNT !== cnt0) begin n_fail++; $display("FAIL sync_err_cnt: got %0d, required %0d", ERR_CNT, cnt0); end
        exp_q.push_back(12'h688);
        send(8'h0F); send(8'h1E); send(8'h3C); send(8'h78);
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sync_realign_missing: pending %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_en_gaps();
        int e0;
        align();
        e0 = err_seen;
        exp_q.push_back(12'h688);
        send(8'h0F);
        step(1'b0, 8'h2D, 1'b0, 1'b0);
        step(1'b0, 8'hFF, 1'b0, 1'b0);
        send(8'h1E); send(8'h3C); send(8'h78);
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL en_gap_word_missing: pending %0d, required 0", exp_q.size()); end
        n_cmp++;
        if (err_seen != e0) begin n_fail++; $display("FAIL en_gap_err: got %0d pulses, required 0", err_seen - e0); end
    endtask

    task automatic test_back_to_back();
        int codes[4];
        int k;
        int len;
        logic [7:0] ps;
        align();
        for (int w = 0; w < 3; w++) begin
            for (int l = 0; l < 4; l++) begin
                k   = $urandom_range(0, 7);
                len = $urandom_range(1, 7);
                ps  = 8'h00;
                for (int i = 0; i < len; i++) ps[(k + i) % 8] = 1'b1;
                codes[l] = k;
                if (l == 3) exp_q.push_back(word4(codes[3], codes[2], codes[1], codes[0]));
                send(ps);
            end
        end
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_word_missing: pending %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        int e0;
        align();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        #1;
        n_cmp++;
        if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL err_clr: got %0d, required 0", ERR_CNT); end
        exp_q.push_back(12'h924);
        repeat (4) send(8'hF0);
        e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            if (i % 4 == 3) exp_q.push_back(12'h924);
            send(8'h00);
        end
        flush();
        n_cmp++;
        if (ERR_CNT !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt: got %0d, required 255", ERR_CNT); end
        n_cmp++;
        if (err_seen - e0 != 300) begin n_fail++; $display("FAIL sat_err_pulses: got %0d, required 300", err_seen - e0); end
        exp_q.push_back(12'h924);
        repeat (4) send(8'hFF);
        flush();
        n_cmp++;
        if (ERR_CNT !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d, required 255", ERR_CNT); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_word_missing: pending %0d, required 0", exp_q.size()); end
        e0 = err_seen;
        send(8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        #1;
        n_cmp++;
        if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL clr_beats_err: got %0d, required 0", ERR_CNT); end
        n_cmp++;
        if (err_seen - e0 != 1) begin n_fail++; $display("FAIL clr_err_pulse: got %0d, required 1", err_seen - e0); end
    endtask

    task automatic test_reset_midword();
        align();
        send(8'h0F); send(8'hFF);
        idle();
        @(negedge CLK);
        RST = 1'b1; EN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_cmp++;
        if (PHE_X4 !== '0) begin n_fail++; $display("FAIL midreset_phe_x4: got %h, required 000", PHE_X4); end
        n_cmp++;
        if (ERR_CNT !== 8'd0) begin n_fail++; $display("FAIL midreset_err_cnt: got %0d, required 0", ERR_CNT); end
        exp_q.push_back(12'h8D1);
        send(8'h1E); send(8'h3C); send(8'h78); send(8'hF0);
        flush();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_word_missing: pending %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bubble();
        test_sync();
        test_en_gaps();
        test_back_to_back();
        test_saturate();
        test_reset_midword();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
